// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment encoding table and output polarity helper
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high segment pattern, bit6 = a ... bit0 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  function automatic logic pol_bit(input logic active_low, input logic b);
    return b ^ active_low;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enabled modulo-DIV counter with terminal-count tick
module tick_gen #(
  parameter int DIV = 4,
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = en && (int'(cnt_q) == DIV - 1);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - N-digit seven-segment scanner with frame snapshots,
// leading-zero blanking, blink and anti-ghosting guard
module seg_scan_mux import seg_pkg::*; #(
  parameter int NDIGITS      = 8,
  parameter int CLK_DIV      = 500,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic [4*NDIGITS-1:0] data,
  input  logic [NDIGITS-1:0]   dp_in,
  input  logic [NDIGITS-1:0]   blink_mask,
  input  logic                 blank_lz,
  output logic [NDIGITS-1:0]   an,
  output logic [6:0]           sev_out,
  output logic                 dp,
  output logic                 frame_tick
);

  localparam int   DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int   CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic AL = (ACTIVE_LOW != 0);

  logic [CW-1:0] div_cnt;
  logic          slot_tick;
  logic [FW-1:0] frame_cnt;
  logic          blink_toggle;
  logic          frame_wrap;
  logic          unused_frame_cnt;

  logic [DW-1:0]        digit_idx_q, digit_idx_d;
  logic                 blink_phase_q, blink_phase_d;
  logic                 first_q, first_d;
  logic [4*NDIGITS-1:0] snap_data_q, snap_data_d;
  logic [NDIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NDIGITS-1:0]   snap_blink_q, snap_blink_d;
  logic                 snap_lz_q, snap_lz_d;
  logic [NDIGITS-1:0]   an_q, an_d;
  logic [6:0]           sev_q, sev_d;
  logic                 dp_q, dp_d;
  logic                 frame_tick_q, frame_tick_d;

  tick_gen #(.DIV(CLK_DIV)) u_slot_div (
    .clk (clk),
    .rst (Rst),
    .en  (1'b1),
    .cnt (div_cnt),
    .tick(slot_tick)
  );

  tick_gen #(.DIV(BLINK_FRAMES)) u_frame_div (
    .clk (clk),
    .rst (Rst),
    .en  (frame_wrap),
    .cnt (frame_cnt),
    .tick(blink_toggle)
  );

  assign frame_wrap       = slot_tick && (int'(digit_idx_q) == NDIGITS - 1);
  assign unused_frame_cnt = ^frame_cnt;

  always_comb begin
    digit_idx_d = digit_idx_q;
    if (slot_tick) begin
      digit_idx_d = frame_wrap ? '0 : digit_idx_q + 1'b1;
    end
    blink_phase_d = blink_phase_q ^ blink_toggle;
    first_d       = 1'b0;
    frame_tick_d  = frame_wrap;
    snap_data_d   = snap_data_q;
    snap_dp_d     = snap_dp_q;
    snap_blink_d  = snap_blink_q;
    snap_lz_d     = snap_lz_q;
    if (first_q || frame_wrap) begin
      snap_data_d  = data;
      snap_dp_d    = dp_in;
      snap_blink_d = blink_mask;
      snap_lz_d    = blank_lz;
    end
  end

  // The snapshot registers are still empty on the first cycle after reset,
  // so that cycle reads the live inputs that are being captured.
  logic [4*NDIGITS-1:0] cur_data;
  logic [NDIGITS-1:0]   cur_dp, cur_blink, an_lg;
  logic                 cur_lz, dp_sel, blink_sel, lz_sel, blank, guard, dp_lg;
  logic [NDIGITS:1]     zero_from;
  logic [3:0]           nib;
  logic [6:0]           seg_lg;

  always_comb begin
    cur_data  = first_q ? data       : snap_data_q;
    cur_dp    = first_q ? dp_in      : snap_dp_q;
    cur_blink = first_q ? blink_mask : snap_blink_q;
    cur_lz    = first_q ? blank_lz   : snap_lz_q;

    zero_from = '1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      zero_from[i] = zero_from[i+1] && (cur_data[4*i +: 4] == 4'h0);
    end

    nib       = 4'h0;
    dp_sel    = 1'b0;
    blink_sel = 1'b0;
    lz_sel    = 1'b0;
    an_lg     = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (digit_idx_q == DW'(i)) begin
        nib       = cur_data[4*i +: 4];
        dp_sel    = cur_dp[i];
        blink_sel = cur_blink[i];
        an_lg[i]  = 1'b1;
      end
    end
    for (int i = 1; i < NDIGITS; i++) begin
      if (digit_idx_q == DW'(i)) begin
        lz_sel = zero_from[i];
      end
    end

    guard  = int'(div_cnt) < GUARD;
    blank  = (lz_sel && cur_lz) || (blink_sel && blink_phase_q);
    seg_lg = (guard || blank) ? SEG_OFF : hex_to_seg(nib);
    dp_lg  = !guard && !blank && dp_sel;
    if (guard) begin
      an_lg = '0;
    end

    for (int i = 0; i < NDIGITS; i++) begin
      an_d[i] = pol_bit(AL, an_lg[i]);
    end
    for (int i = 0; i < 7; i++) begin
      sev_d[i] = pol_bit(AL, seg_lg[i]);
    end
    dp_d = pol_bit(AL, dp_lg);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      digit_idx_q   <= '0;
      blink_phase_q <= 1'b0;
      first_q       <= 1'b1;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_blink_q  <= '0;
      snap_lz_q     <= 1'b0;
      an_q          <= {NDIGITS{AL}};
      sev_q         <= {7{AL}};
      dp_q          <= AL;
      frame_tick_q  <= 1'b0;
    end else begin
      digit_idx_q   <= digit_idx_d;
      blink_phase_q <= blink_phase_d;
      first_q       <= first_d;
      snap_data_q   <= snap_data_d;
      snap_dp_q     <= snap_dp_d;
      snap_blink_q  <= snap_blink_d;
      snap_lz_q     <= snap_lz_d;
      an_q          <= an_d;
      sev_q         <= sev_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign sev_out    = sev_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - randomized self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

  localparam int N  = 8;
  localparam int CD = 8;
  localparam int G  = 2;
  localparam int BF = 2;
  localparam int FP = N * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  sev_out;
  logic        dp;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NDIGITS(N), .CLK_DIV(CD), .GUARD(G), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .Rst(rst), .data(data), .dp_in(dp_in), .blink_mask(blink_mask),
    .blank_lz(blank_lz), .an(an), .sev_out(sev_out), .dp(dp), .frame_tick(frame_tick)
  );

  // Reference model: derives everything from elapsed time since reset.
  logic [6:0]  seg_tab [16];
  logic [31:0] sn_data;
  logic [7:0]  sn_dp, sn_bl;
  logic        sn_lz;
  int          s, md, mdv, mfr;
  logic        mblank;
  logic [7:0]  exp_an;
  logic [6:0]  exp_sev;
  logic        exp_dp, exp_ft;
  wire  [16:0] got_v  = {an, sev_out, dp, frame_tick};
  wire  [16:0] want_v = {exp_an, exp_sev, exp_dp, exp_ft};

  initial begin
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  end

  always @(posedge clk) begin
    if (rst) begin
      s = 0;
      exp_an = 8'hFF; exp_sev = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
    end else begin
      if (s == 0) begin
        sn_data = data; sn_dp = dp_in; sn_bl = blink_mask; sn_lz = blank_lz;
      end
      md  = (s / CD) % N;
      mdv = s % CD;
      mfr = s / FP;
      exp_ft = ((s + 1) % FP) == 0;
      if (mdv < G) begin
        exp_an = 8'hFF; exp_sev = 7'h7F; exp_dp = 1'b1;
      end else begin
        mblank = (md > 0 && sn_lz && ((sn_data >> (4 * md)) == 32'h0)) ||
                 (((mfr / BF) % 2) == 1 && sn_bl[md]);
        exp_an  = ~(8'h01 << md);
        exp_sev = mblank ? 7'h7F : ~seg_tab[sn_data[4*md +: 4]];
        exp_dp  = mblank ? 1'b1 : ~sn_dp[md];
      end
      if (((s + 1) % FP) == 0) begin
        sn_data = data; sn_dp = dp_in; sn_bl = blink_mask; sn_lz = blank_lz;
      end
      s++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    data = $urandom; dp_in = 8'hFF; blink_mask = 8'h00; blank_lz = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (got_v !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold got=%h want=%h", got_v, {8'hFF, 7'h7F, 1'b1, 1'b0});
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= G + 1; c++) begin
      @(negedge clk);
      n_checks++;
      if (an !== ((c == G + 1) ? 8'hFE : 8'hFF)) begin
        n_fail++;
        $display("FAIL reset_first_anode c=%0d an=%h want=%h", c, an,
                 (c == G + 1) ? 8'hFE : 8'hFF);
      end
    end
  endtask

  task automatic test_basic();
    int last_ft = -1;
    int n_ft = 0;
    data = 32'h0123_4567; dp_in = 8'h00; blink_mask = 8'h00; blank_lz = 1'b0;
    do_reset();
    for (int c = 1; c <= 3 * FP; c++) begin
      @(negedge clk);
      n_checks++;
      if (got_v !== want_v) begin
        n_fail++;
        $display("FAIL basic_model c=%0d got=%h want=%h", c, got_v, want_v);
      end
      if (an === 8'hFE) begin
        n_checks++;
        if (sev_out !== 7'b0001111) begin
          n_fail++;
          $display("FAIL basic_digit0 sev=%b want=0001111", sev_out);
        end
      end
      if (an === 8'h7F) begin
        n_checks++;
        if (sev_out !== 7'b0000001) begin
          n_fail++;
          $display("FAIL basic_digit7 sev=%b want=0000001", sev_out);
        end
      end
      if (frame_tick === 1'b1) begin
        if (last_ft >= 0) begin
          n_checks++;
          if (c - last_ft != FP) begin
            n_fail++;
            $display("FAIL basic_frame_period got=%0d want=%0d", c - last_ft, FP);
          end
        end
        last_ft = c;
        n_ft++;
      end
    end
    n_checks++;
    if (n_ft != 3) begin
      n_fail++;
      $display("FAIL basic_frame_count got=%0d want=3", n_ft);
    end
  endtask

  task automatic test_lz();
    data = 32'h0000_00A0; dp_in = 8'h00; blink_mask = 8'h00; blank_lz = 1'b1;
    do_reset();
    for (int c = 1; c <= FP; c++) begin
      @(negedge clk);
      n_checks++;
      if (got_v !== want_v) begin
        n_fail++;
        $display("FAIL lz_model c=%0d got=%h want=%h", c, got_v, want_v);
      end
      if (an !== 8'hFF) begin
        n_checks++;
        if (an === 8'hFD && sev_out !== 7'b0001000) begin
          n_fail++;
          $display("FAIL lz_digit1 sev=%b want=0001000", sev_out);
        end else if (an === 8'hFE && sev_out !== 7'b0000001) begin
          n_fail++;
          $display("FAIL lz_digit0 sev=%b want=0000001", sev_out);
        end else if (an !== 8'hFD && an !== 8'hFE && sev_out !== 7'h7F) begin
          n_fail++;
          $display("FAIL lz_upper an=%h sev=%b want=1111111", an, sev_out);
        end
      end
    end
  endtask

  task automatic test_tear();
    int c = 0;
    data = 32'h1111_1111; dp_in = 8'h00; blink_mask = 8'h00; blank_lz = 1'b0;
    do_reset();
    while (an !== 8'hF7 && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (an !== 8'hF7) begin
      n_fail++;
      $display("FAIL tear_wait_digit3 an=%h want=f7", an);
    end
    data = 32'h2222_2222;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      n_checks++;
      if (got_v !== want_v) begin
        n_fail++;
        $display("FAIL tear_model c=%0d got=%h want=%h", c, got_v, want_v);
      end
      if (an !== 8'hFF && sev_out !== 7'b1001111) begin
        n_fail++;
        $display("FAIL tear_old_frame an=%h sev=%b want=1001111", an, sev_out);
      end
    end while (frame_tick !== 1'b1 && c < 100);
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL tear_wait_frame ft=%b want=1", frame_tick);
    end
    for (int k = 1; k < FP; k++) begin
      @(negedge clk);
      n_checks++;
      if (an !== 8'hFF && sev_out !== 7'b0010010) begin
        n_fail++;
        $display("FAIL tear_new_frame an=%h sev=%b want=0010010", an, sev_out);
      end
    end
  endtask

  task automatic test_blink();
    int blank0 = 0;
    int blank1 = 0;
    data = $urandom; dp_in = 8'h00; blink_mask = 8'h01; blank_lz = 1'b0;
    do_reset();
    for (int c = 1; c <= 8 * FP; c++) begin
      @(negedge clk);
      n_checks++;
      if (got_v !== want_v) begin
        n_fail++;
        $display("FAIL blink_model c=%0d got=%h want=%h", c, got_v, want_v);
      end
      if (an === 8'hFE && sev_out === 7'h7F) blank0++;
      if (an === 8'hFD && sev_out === 7'h7F) blank1++;
    end
    n_checks++;
    if (blank0 != 4 * (CD - G) || blank1 != 0) begin
      n_fail++;
      $display("FAIL blink_counts d0=%0d d1=%0d want d0=%0d d1=0", blank0, blank1, 4 * (CD - G));
    end
  endtask

  task automatic test_dp_guard();
    data = $urandom; dp_in = 8'h04; blink_mask = 8'h00; blank_lz = 1'b0;
    do_reset();
    for (int c = 1; c <= 2 * FP; c++) begin
      @(negedge clk);
      n_checks++;
      if (got_v !== want_v) begin
        n_fail++;
        $display("FAIL dpg_model c=%0d got=%h want=%h", c, got_v, want_v);
      end
      n_checks++;
      if (dp !== (an !== 8'hFB)) begin
        n_fail++;
        $display("FAIL dpg_dp an=%h dp=%b want=%b", an, dp, an !== 8'hFB);
      end
      if (((c - 1) % CD) < G) begin
        n_checks++;
        if (an !== 8'hFF) begin
          n_fail++;
          $display("FAIL dpg_guard c=%0d an=%h want=ff", c, an);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int c = 0;
    logic [7:0] first_an;
    data = $urandom; dp_in = $urandom; blink_mask = 8'h00; blank_lz = 1'b0;
    do_reset();
    while (an !== 8'hDF && c < 400) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (an !== 8'hDF) begin
      n_fail++;
      $display("FAIL mrst_wait_digit5 an=%h want=df", an);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    data = $urandom; dp_in = $urandom;
    @(negedge clk);
    n_checks++;
    if (got_v !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mrst_inactive got=%h want=%h", got_v, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    rst = 1'b0;
    first_an = 8'hFF;
    for (int k = 1; k <= FP; k++) begin
      @(negedge clk);
      n_checks++;
      if (got_v !== want_v) begin
        n_fail++;
        $display("FAIL mrst_model k=%0d got=%h want=%h", k, got_v, want_v);
      end
      if (first_an === 8'hFF) first_an = an;
    end
    n_checks++;
    if (first_an !== 8'hFE) begin
      n_fail++;
      $display("FAIL mrst_restart_digit an=%h want=fe", first_an);
    end
  endtask

  task automatic test_random();
    data = $urandom >> (4 * $urandom_range(0, 8));
    dp_in = $urandom; blink_mask = $urandom; blank_lz = $urandom_range(0, 1);
    do_reset();
    for (int c = 1; c <= 6 * FP; c++) begin
      @(negedge clk);
      n_checks++;
      if (got_v !== want_v) begin
        n_fail++;
        $display("FAIL random_model c=%0d got=%h want=%h", c, got_v, want_v);
      end
      if ($urandom_range(0, 15) == 0) begin
        data = $urandom >> (4 * $urandom_range(0, 8));
        dp_in = $urandom; blink_mask = $urandom; blank_lz = $urandom_range(0, 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_tear();
    test_blink();
    test_dp_guard();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
